// File: rtl/decode_if.sv
// Fetch-to-decode bundle: instruction/PC from fetch, decode/execute register
// outputs and the register-file read addresses. Counter signals exist only with DECODE_PERF_EN.
interface decode_if;
    logic        stall_in;
    logic        flush_in;
    logic [63:0] pc_in;
    logic [63:0] instr_in;
    logic        branch_predicted_taken_in;

    logic        stall_out;
    logic [4:0]  rs1_addr_out;
    logic [4:0]  rs2_addr_out;
    logic        valid_out;
    logic [63:0] pc_out;
    logic [63:0] instr_out;
    logic [63:0] imm_out;
    logic [4:0]  rd_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [2:0]  funct3_out;
    logic [7:0]  opcode_out;
    logic        is_load_out;
    logic        is_store_out;
    logic        is_branch_out;
    logic        is_jump_out;
    logic        writes_rd_out;
    logic        branch_predicted_taken_out;
`ifdef DECODE_PERF_EN
    logic [31:0] stall_count_out;
    logic [31:0] bubble_count_out;
`endif

    modport slave (
        input  stall_in, flush_in, pc_in, instr_in, branch_predicted_taken_in,
        output stall_out, rs1_addr_out, rs2_addr_out, valid_out, pc_out, instr_out,
               imm_out, rd_out, rs1_out, rs2_out, funct3_out, opcode_out,
               is_load_out, is_store_out, is_branch_out, is_jump_out, writes_rd_out,
               branch_predicted_taken_out
`ifdef DECODE_PERF_EN
        , stall_count_out, bubble_count_out
`endif
    );

    modport master (
        output stall_in, flush_in, pc_in, instr_in, branch_predicted_taken_in,
        input  stall_out, rs1_addr_out, rs2_addr_out, valid_out, pc_out, instr_out,
               imm_out, rd_out, rs1_out, rs2_out, funct3_out, opcode_out,
               is_load_out, is_store_out, is_branch_out, is_jump_out, writes_rd_out,
               branch_predicted_taken_out
`ifdef DECODE_PERF_EN
        , stall_count_out, bubble_count_out
`endif
    );
endinterface

// File: rtl/decode.sv
// Decode stage: field split, immediate generation, load-use hazard detection and
// the decode/execute pipeline register. Optional stall/bubble counters under DECODE_PERF_EN.
module decode (
    input logic     clk,
    input logic     reset,
    decode_if.slave bus
);
    localparam logic [7:0]  OPCODE_LOAD   = 8'h03;
    localparam logic [7:0]  OPCODE_OP_IMM = 8'h13;
    localparam logic [7:0]  OPCODE_AUIPC  = 8'h17;
    localparam logic [7:0]  OPCODE_STORE  = 8'h23;
    localparam logic [7:0]  OPCODE_OP     = 8'h33;
    localparam logic [7:0]  OPCODE_LUI    = 8'h37;
    localparam logic [7:0]  OPCODE_BRANCH = 8'h63;
    localparam logic [7:0]  OPCODE_JALR   = 8'h67;
    localparam logic [7:0]  OPCODE_JAL    = 8'h6F;
    localparam logic [63:0] INSTR_NOP     = 64'h0000_0000_0000_0013;

    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_field;
    logic [63:0] imm;

    assign opcode    = bus.instr_in[7:0];
    assign rd        = bus.instr_in[12:8];
    assign funct3    = bus.instr_in[15:13];
    assign rs1       = bus.instr_in[20:16];
    assign rs2       = bus.instr_in[25:21];
    assign imm_field = bus.instr_in[63:32];

    assign imm = (opcode == OPCODE_LUI || opcode == OPCODE_AUIPC)
               ? {imm_field, 32'b0}
               : {{32{imm_field[31]}}, imm_field};

    logic uses_rs1;
    logic uses_rs2;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic rd_class;
    logic writes_rd;

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        rd_class  = 1'b0;
        case (opcode)
            OPCODE_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                rd_class = 1'b1;
            end
            OPCODE_OP_IMM: begin
                uses_rs1 = 1'b1;
                rd_class = 1'b1;
            end
            OPCODE_LOAD: begin
                uses_rs1 = 1'b1;
                is_load  = 1'b1;
                rd_class = 1'b1;
            end
            OPCODE_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                is_store = 1'b1;
            end
            OPCODE_BRANCH: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                is_branch = 1'b1;
            end
            OPCODE_JAL: begin
                is_jump  = 1'b1;
                rd_class = 1'b1;
            end
            OPCODE_JALR: begin
                uses_rs1 = 1'b1;
                is_jump  = 1'b1;
                rd_class = 1'b1;
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                rd_class = 1'b1;
            end
            default: ;
        endcase
    end

    // x0 is hardwired, so writing it is never a real write.
    assign writes_rd = rd_class && (rd != 5'd0);

    logic        valid_q,     valid_d;
    logic [63:0] pc_q,        pc_d;
    logic [63:0] instr_q,     instr_d;
    logic [63:0] imm_q,       imm_d;
    logic [4:0]  rd_q,        rd_d;
    logic [4:0]  rs1_q,       rs1_d;
    logic [4:0]  rs2_q,       rs2_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [7:0]  opcode_q,    opcode_d;
    logic        is_load_q,   is_load_d;
    logic        is_store_q,  is_store_d;
    logic        is_branch_q, is_branch_d;
    logic        is_jump_q,   is_jump_d;
    logic        writes_rd_q, writes_rd_d;
    logic        bpt_q,       bpt_d;

    logic hazard;
    logic load_bubble;
    logic load_instr;

    // Load in EX whose destination feeds a source register of the incoming instruction.
    assign hazard = valid_q && is_load_q && (rd_q != 5'd0) && !bus.flush_in
                 && ((uses_rs1 && (rs1 == rd_q)) || (uses_rs2 && (rs2 == rd_q)));

    assign load_bubble = !bus.stall_in && (bus.flush_in || hazard);
    assign load_instr  = !bus.stall_in && !bus.flush_in && !hazard;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        funct3_d    = funct3_q;
        opcode_d    = opcode_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        is_branch_d = is_branch_q;
        is_jump_d   = is_jump_q;
        writes_rd_d = writes_rd_q;
        bpt_d       = bpt_q;
        if (load_bubble) begin
            valid_d     = 1'b0;
            pc_d        = bus.pc_in;
            instr_d     = INSTR_NOP;
            imm_d       = 64'd0;
            rd_d        = 5'd0;
            rs1_d       = 5'd0;
            rs2_d       = 5'd0;
            funct3_d    = 3'd0;
            opcode_d    = INSTR_NOP[7:0];
            is_load_d   = 1'b0;
            is_store_d  = 1'b0;
            is_branch_d = 1'b0;
            is_jump_d   = 1'b0;
            writes_rd_d = 1'b0;
            bpt_d       = 1'b0;
        end else if (load_instr) begin
            valid_d     = 1'b1;
            pc_d        = bus.pc_in;
            instr_d     = bus.instr_in;
            imm_d       = imm;
            rd_d        = rd;
            rs1_d       = rs1;
            rs2_d       = rs2;
            funct3_d    = funct3;
            opcode_d    = opcode;
            is_load_d   = is_load;
            is_store_d  = is_store;
            is_branch_d = is_branch;
            is_jump_d   = is_jump;
            writes_rd_d = writes_rd;
            bpt_d       = bus.branch_predicted_taken_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= 64'd0;
            instr_q     <= INSTR_NOP;
            imm_q       <= 64'd0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            funct3_q    <= 3'd0;
            opcode_q    <= 8'd0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
            is_jump_q   <= 1'b0;
            writes_rd_q <= 1'b0;
            bpt_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            funct3_q    <= funct3_d;
            opcode_q    <= opcode_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            is_branch_q <= is_branch_d;
            is_jump_q   <= is_jump_d;
            writes_rd_q <= writes_rd_d;
            bpt_q       <= bpt_d;
        end
    end

`ifdef DECODE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    assign stall_cnt_d  = (hazard && !bus.stall_in) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    assign bubble_cnt_d = load_bubble ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_count_out  = stall_cnt_q;
    assign bus.bubble_count_out = bubble_cnt_q;
`endif

    assign bus.stall_out    = bus.stall_in || hazard;
    assign bus.rs1_addr_out = rs1;
    assign bus.rs2_addr_out = rs2;

    assign bus.valid_out                  = valid_q;
    assign bus.pc_out                     = pc_q;
    assign bus.instr_out                  = instr_q;
    assign bus.imm_out                    = imm_q;
    assign bus.rd_out                     = rd_q;
    assign bus.rs1_out                    = rs1_q;
    assign bus.rs2_out                    = rs2_q;
    assign bus.funct3_out                 = funct3_q;
    assign bus.opcode_out                 = opcode_q;
    assign bus.is_load_out                = is_load_q;
    assign bus.is_store_out               = is_store_q;
    assign bus.is_branch_out              = is_branch_q;
    assign bus.is_jump_out                = is_jump_q;
    assign bus.writes_rd_out              = writes_rd_q;
    assign bus.branch_predicted_taken_out = bpt_q;
endmodule

// File: doc/decode.md
# decode

Decode stage of the 64-bit pipeline, directly downstream of fetch.
- Consumes the fetched instruction word, its PC and the branch-prediction bit.
- Splits the word into register indices, immediate and control flags.
- Drives register-file read addresses combinationally, one cycle ahead of the registered outputs.
- Detects load-use hazards and back-pressures fetch.
- Registers everything into the decode/execute pipeline register, honouring stall and flush.

## Interface
Parameters:
- none (register index width fixed at 5, datapath 64)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears the pipeline register and counters
- stall_in  input  1  downstream stall; hold all registered state
- flush_in  input  1  discard the incoming instruction; load a bubble
- pc_in  input  64  PC of the incoming instruction, from fetch
- instr_in  input  64  instruction word, from fetch
- branch_predicted_taken_in  input  1  fetch prediction bit
- stall_out  output  1  to fetch: `stall_in | hazard`
- rs1_addr_out / rs2_addr_out  output  5 each  combinational `instr_in[20:16]` / `instr_in[25:21]`
- valid_out  output  1  registered; 0 means bubble
- pc_out, instr_out, imm_out  output  64 each  registered
- rd_out, rs1_out, rs2_out  output  5 each  registered
- funct3_out  output  3  registered
- opcode_out  output  8  registered
- is_load_out, is_store_out, is_branch_out, is_jump_out, writes_rd_out, branch_predicted_taken_out  output  1 each  registered
- stall_count_out, bubble_count_out  output  32 each  present only with DECODE_PERF_EN

## Operation
Field layout:
- opcode `[7:0]`, rd `[12:8]`, funct3 `[15:13]`, rs1 `[20:16]`, rs2 `[25:21]`, immediate `[63:32]`.

Immediate:
- `OPCODE_LUI` and `OPCODE_AUIPC`: `{instr[63:32], 32'b0}`.
- All other opcodes: `instr[63:32]` sign-extended to 64 bits.

Register usage:
- uses_rs1: OP, OP_IMM, LOAD, STORE, BRANCH, JALR.
- uses_rs2: OP, STORE, BRANCH.

Flags:
- writes_rd: OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC, with rd≠0.
- is_jump: JAL or JALR.
- Unknown opcode: all flags 0, valid_out still 1.

Hazard (combinational), all of the following true:
- valid_out = 1
- is_load_out = 1
- rd_out ≠ 0
- (uses_rs1 and rs1 = rd_out) or (uses_rs2 and rs2 = rd_out)
- flush_in = 0

Per-edge priority (highest first):
1. reset: valid_out=0, instr_out=`INSTR_NOP`, every other output register 0.
2. stall_in=1: hold every register. A coincident flush_in is ignored; the controller must hold flush until stall drops.
3. flush_in=1: load a bubble — valid_out=0, instr_out=`INSTR_NOP`, all flags 0, pc_out=pc_in.
4. hazard=1: load a bubble. stall_out=1 makes fetch hold, so the same instruction is re-presented next cycle.
5. otherwise: load the decoded instruction with valid_out=1.

## Timing
- Latency: 1 cycle from instr_in to the registered outputs.
- rs*_addr_out are zero-latency, so a synchronous register file returns data aligned with the registered outputs.
- Load-use costs exactly one bubble:
  - Cycle N: load in EX and dependent instruction at input → bubble, stall_out=1.
  - Cycle N+1: EX holds the bubble, hazard clears, dependent instruction is loaded.
- stall_out is combinational from stall_in and the registered state.
  - No combinational path from instr_in except through hazard.
- Reset asserted mid-stream clears state immediately (async). The first edge after release loads instr_in normally.

## Configuration
Macro: DECODE_PERF_EN.
- Defined:
  - stall_count_out increments on every edge where hazard=1 and stall_in=0.
  - bubble_count_out increments on every edge that loads a bubble (flush or hazard).
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: both counters and ports are absent; behaviour is otherwise identical.

## Test plan
- Reset release, then `addi x5,x0,-1` (OP_IMM, rd=5, imm field `0xFFFFFFFF`) at pc_in `0x1000` → next cycle valid_out=1, rd_out=5, imm_out=`0xFFFFFFFF_FFFFFFFF`, writes_rd_out=1, pc_out=`0x1000`.
- LOAD rd=7, then OP rs1=7 → cycle after load: valid_out=0, stall_out=1 for one cycle; following cycle: OP with rs1_out=7, valid_out=1; stall_count_out=1.
- LOAD rd=0, then OP rs1=0 → no bubble, stall_out=0.
- flush_in=1 with a BRANCH at the input → valid_out=0, instr_out=`INSTR_NOP`, is_branch_out=0; bubble_count_out increments by 1.
- stall_in high for 3 cycles with a changing instr_in → all outputs frozen; stall_out=1 throughout. flush_in asserted during stall is ignored.
- LUI with imm field `0x80000000` → imm_out=`0x80000000_00000000`. Assert reset mid-stall → valid_out=0 immediately, without waiting for a clock edge.
